// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control types and constants
package pipe_ctrl_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_e;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [1:0] No_Fw  = 2'b00;
  localparam logic [1:0] WB_Fw  = 2'b01;
  localparam logic [1:0] MEM_Fw = 2'b10;
  // control vector order: {PC_WEN, IF_ID_WEN, ID_EX_WEN, EX_MA_WEN, IF_ID_Flush, ID_EX_Flush, MA_WB_Bubble}
  localparam logic [6:0] CTRL_RUN      = 7'b1111000;
  localparam logic [6:0] CTRL_MEM_WAIT = 7'b0000001;
  localparam logic [6:0] CTRL_REDIRECT = 7'b1111110;
  localparam logic [6:0] CTRL_LOAD_USE = 7'b0011010;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at MAX, with sync clear and async reset
module sat_counter #(
  parameter int W = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  // next count: clear wins, otherwise step until saturated
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, redirect and memory wait
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rd_EX,
  input  logic [4:0]       Rs1_ID,
  input  logic [4:0]       Rs2_ID,
  input  logic             Rs1_Used_ID,
  input  logic             Rs2_Used_ID,
  input  logic             Branch_Taken_EX,
  input  logic             DMem_Req_MA,
  input  logic             DMem_Ready,
  output logic             PC_WEN,
  output logic             IF_ID_WEN,
  output logic             ID_EX_WEN,
  output logic             EX_MA_WEN,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MA_WB_Bubble,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Cycles
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  state_e state_q, state_d;
  logic mem_timeout_q, mem_timeout_d;
  logic mem_wait, load_use, redirect;
  logic [6:0] ctrl;
  logic [WAIT_W-1:0] wait_cnt;
  // hazard detection
  always_comb begin
    mem_wait = DMem_Req_MA && !DMem_Ready;
    load_use = MemRead_EX && Rd_EX != REG_X0 &&
               ((Rs1_Used_ID && Rs1_ID == Rd_EX) || (Rs2_Used_ID && Rs2_ID == Rd_EX));
    redirect = Branch_Taken_EX;
  end
  // state and sticky timeout registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= ST_RUN;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  // next state: enter WAIT on a memory stall, leave when memory is ready
  always_comb begin
    state_d = state_q == ST_RUN ? (mem_wait ? ST_WAIT : ST_RUN) : (DMem_Ready ? ST_RUN : ST_WAIT);
    mem_timeout_d = mem_timeout_q || (state_q == ST_WAIT && wait_cnt == WAIT_MAX);
  end
  // pipeline controls, prioritised memory wait > redirect > load-use
  always_comb
    ctrl = !rst_n ? CTRL_RUN : mem_wait ? CTRL_MEM_WAIT : redirect ? CTRL_REDIRECT :
           load_use ? CTRL_LOAD_USE : CTRL_RUN;
  assign {PC_WEN, IF_ID_WEN, ID_EX_WEN, EX_MA_WEN, IF_ID_Flush, ID_EX_Flush, MA_WB_Bubble} = ctrl;
  assign Mem_Timeout = mem_timeout_q;
  sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_WAIT && DMem_Ready),
    .inc   (state_q == ST_RUN ? mem_wait : !DMem_Ready),
    .cnt   (wait_cnt)
  );
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (!PC_WEN),
    .cnt   (Stall_Cycles)
  );
endmodule
